// File: rtl/lib_pkg.sv
// Shared library package for the arbiter slice.
//   arb_state_e   : arbiter FSM states (IDLE, BUSY)
//   onehot_to_bin : binary index of a one-hot vector (up to LIB_MAX_N bits)
//   rotl1         : rotate-left-by-1 within the low n bits of a vector
package lib_pkg;

  localparam int unsigned LIB_MAX_N     = 32;
  localparam int unsigned LIB_MAX_IDX_W = 5;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } arb_state_e;

  // OR-reduction encoder: exact for one-hot input, 0 for all-zero input.
  function automatic logic [LIB_MAX_IDX_W-1:0] onehot_to_bin(
    input logic [LIB_MAX_N-1:0] oh
  );
    logic [LIB_MAX_IDX_W-1:0] idx;
    idx = '0;
    for (int unsigned i = 0; i < LIB_MAX_N; i++) begin
      if (oh[i]) idx |= i[LIB_MAX_IDX_W-1:0];
    end
    return idx;
  endfunction

  // Rotate the low n bits left by one; bits at or above n are cleared.
  function automatic logic [LIB_MAX_N-1:0] rotl1(
    input logic [LIB_MAX_N-1:0] v,
    input int unsigned          n
  );
    logic [LIB_MAX_N-1:0] r;
    r = '0;
    for (int unsigned i = 0; i < LIB_MAX_N; i++) begin
      if (i < n) begin
        if (i == n - 1) r[0] = v[i];
        else            r[i+1] = v[i];
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/lib_ffs.sv
// Find-first-set with a one-hot starting point and wrap-around.
//   vect    : candidate bits
//   base    : one-hot start position (searched first)
//   first   : one-hot first set bit of vect at/after base, wrapping; 0 if vect==0
// LSB_MSB=1 searches upward from base, LSB_MSB=0 searches downward.
module lib_ffs #(
  parameter int unsigned WIDTH   = 4,
  parameter bit          LSB_MSB = 1'b1
) (
  input  logic [WIDTH-1:0] vect,
  input  logic [WIDTH-1:0] base,
  output logic [WIDTH-1:0] first
);

  logic [WIDTH-1:0]   v_n;
  logic [WIDTH-1:0]   b_n;
  logic [WIDTH-1:0]   f_n;
  logic [2*WIDTH-1:0] dbl;
  logic [2*WIDTH-1:0] dbl_hit;

  always_comb begin
    v_n = '0;
    b_n = '0;
    for (int unsigned i = 0; i < WIDTH; i++) begin
      v_n[i] = LSB_MSB ? vect[i] : vect[WIDTH-1-i];
      b_n[i] = LSB_MSB ? base[i] : base[WIDTH-1-i];
    end
    // Subtracting the one-hot base from the doubled vector borrows up to the
    // first set bit at/above base; the upper copy provides the wrap.
    dbl     = {v_n, v_n};
    dbl_hit = dbl & ~(dbl - {{WIDTH{1'b0}}, b_n});
    f_n     = dbl_hit[WIDTH-1:0] | dbl_hit[2*WIDTH-1:WIDTH];
    first   = '0;
    for (int unsigned i = 0; i < WIDTH; i++) begin
      first[i] = LSB_MSB ? f_n[i] : f_n[WIDTH-1-i];
    end
  end

endmodule

// File: rtl/lib_rr_arb.sv
// Round-robin packet arbiter: N streaming sources onto one sink.
// Grant is held for a whole packet (until a beat with last is accepted),
// then priority rotates to one past the winner. One idle bubble between
// packets.
//   clk, rst              : clock, synchronous active-high reset
//   in_valid/in_last      : per-requester valid and end-of-packet
//   in_data               : flat, requester i at [i*DATA_W +: DATA_W]
//   in_ready              : per-requester ready (granted requester only)
//   out_valid/last/data   : downstream beat, combinational from granted source
//   out_ready             : downstream ready
//   gnt / gnt_idx         : one-hot grant and its index (0 when idle)
module lib_rr_arb
  import lib_pkg::*;
#(
  parameter  int unsigned N      = 4,
  parameter  int unsigned DATA_W = 8,
  localparam int unsigned IDX_W  = $clog2(N)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [N-1:0]        in_valid,
  input  logic [N-1:0]        in_last,
  input  logic [N*DATA_W-1:0] in_data,
  output logic [N-1:0]        in_ready,
  output logic                out_valid,
  output logic                out_last,
  output logic [DATA_W-1:0]   out_data,
  input  logic                out_ready,
  output logic [N-1:0]        gnt,
  output logic [IDX_W-1:0]    gnt_idx
);

  arb_state_e        state_q, state_d;
  logic [N-1:0]      gnt_q, gnt_d;
  logic [IDX_W-1:0]  gnt_idx_q, gnt_idx_d;
  logic [N-1:0]      base_q, base_d;
  logic [N-1:0]      winner;
  logic [DATA_W-1:0] data_arr [N];

  lib_ffs #(
    .WIDTH   (N),
    .LSB_MSB (1'b1)
  ) u_ffs (
    .vect  (in_valid),
    .base  (base_q),
    .first (winner)
  );

  always_comb begin
    for (int unsigned i = 0; i < N; i++) begin
      data_arr[i] = in_data[i*DATA_W +: DATA_W];
    end
  end

  always_comb begin
    state_d   = state_q;
    gnt_d     = gnt_q;
    gnt_idx_d = gnt_idx_q;
    base_d    = base_q;
    out_valid = 1'b0;
    out_last  = 1'b0;
    out_data  = '0;
    in_ready  = '0;
    case (state_q)
      IDLE: begin
        if (|in_valid) begin
          gnt_d     = winner;
          gnt_idx_d = IDX_W'(onehot_to_bin(LIB_MAX_N'(winner)));
          state_d   = BUSY;
        end
      end
      BUSY: begin
        out_valid = in_valid[gnt_idx_q];
        out_last  = in_last[gnt_idx_q];
        out_data  = data_arr[gnt_idx_q];
        in_ready  = gnt_q & {N{out_ready}};
        if (out_valid && out_ready && out_last) begin
          base_d    = N'(rotl1(LIB_MAX_N'(gnt_q), N));
          gnt_d     = '0;
          gnt_idx_d = '0;
          state_d   = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      gnt_q     <= '0;
      gnt_idx_q <= '0;
      base_q    <= N'(1);
    end else begin
      state_q   <= state_d;
      gnt_q     <= gnt_d;
      gnt_idx_q <= gnt_idx_d;
      base_q    <= base_d;
    end
  end

  assign gnt     = gnt_q;
  assign gnt_idx = gnt_idx_q;

  a_gnt_onehot0: assert property (@(posedge clk) disable iff (rst) $onehot0(gnt_q));
  a_gnt_idle:    assert property (@(posedge clk) disable iff (rst)
                                  ((gnt_q == '0) == (state_q == IDLE)));
  a_base_onehot: assert property (@(posedge clk) disable iff (rst) $onehot(base_q));
  a_ready_gnt:   assert property (@(posedge clk) disable iff (rst)
                                  ((in_ready & ~gnt_q) == '0));

endmodule

// File: tb/tb_lib_rr_arb.sv
module tb_lib_rr_arb;

  localparam int unsigned N      = 4;
  localparam int unsigned DATA_W = 8;
  localparam int unsigned IDX_W  = 2;

  logic                clk;
  logic                rst;
  logic [N-1:0]        in_valid;
  logic [N-1:0]        in_last;
  logic [N*DATA_W-1:0] in_data;
  logic [N-1:0]        in_ready;
  logic                out_valid;
  logic                out_last;
  logic [DATA_W-1:0]   out_data;
  logic                out_ready;
  logic [N-1:0]        gnt;
  logic [IDX_W-1:0]    gnt_idx;

  int checks = 0;
  int errors = 0;

  typedef logic [DATA_W:0] beat_t;  // {last, data}
  beat_t exp_q[$];
  beat_t rq[N][$];

  lib_rr_arb #(.N(N), .DATA_W(DATA_W)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_last   (in_last),
    .in_data   (in_data),
    .in_ready  (in_ready),
    .out_valid (out_valid),
    .out_last  (out_last),
    .out_data  (out_data),
    .out_ready (out_ready),
    .gnt       (gnt),
    .gnt_idx   (gnt_idx)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_idle();
    in_valid  = '0;
    in_last   = '0;
    in_data   = '0;
    out_ready = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    drive_idle();
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    drive_idle();
    tick();
    tick();
    checks++; if (gnt !== 4'b0000) begin errors++; $display("FAIL reset_gnt got %b want 0000", gnt); end
    checks++; if (gnt_idx !== 2'd0) begin errors++; $display("FAIL reset_gnt_idx got %0d want 0", gnt_idx); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got %b want 0", out_valid); end
    checks++; if (in_ready !== 4'b0000) begin errors++; $display("FAIL reset_in_ready got %b want 0000", in_ready); end
    checks++; if (dut.base_q !== 4'b0001) begin errors++; $display("FAIL reset_base got %b want 0001", dut.base_q); end
    rst = 1'b0;
  endtask

  task automatic test_single();
    beat_t e;
    in_valid  = 4'b0100;
    in_last   = 4'b0100;
    in_data   = {8'hD3, 8'hA2, 8'hD1, 8'hD0};
    out_ready = 1'b1;
    exp_q.push_back({1'b1, 8'hA2});
    #1;
    checks++; if (gnt !== 4'b0000) begin errors++; $display("FAIL single_latency got %b want 0000", gnt); end
    tick();
    checks++; if (gnt !== 4'b0100) begin errors++; $display("FAIL single_gnt got %b want 0100", gnt); end
    checks++; if (gnt_idx !== 2'd2) begin errors++; $display("FAIL single_gnt_idx got %0d want 2", gnt_idx); end
    checks++; if (in_ready !== 4'b0100) begin errors++; $display("FAIL single_in_ready got %b want 0100", in_ready); end
    checks++;
    if (!(out_valid && out_ready) || exp_q.size() == 0) begin
      errors++; $display("FAIL single_beat got valid %b want valid 1", out_valid);
    end else begin
      e = exp_q.pop_front();
      if ({out_last, out_data} !== e) begin errors++; $display("FAIL single_beat got %h want %h", {out_last, out_data}, e); end
    end
    tick();
    in_valid = '0;
    #1;
    checks++; if (gnt !== 4'b0000) begin errors++; $display("FAIL single_idle got %b want 0000", gnt); end
    checks++; if (dut.base_q !== 4'b1000) begin errors++; $display("FAIL single_base got %b want 1000", dut.base_q); end
  endtask

  task automatic test_wrap();
    beat_t e;
    checks++; if (dut.base_q !== 4'b1000) begin errors++; $display("FAIL wrap_base_pre got %b want 1000", dut.base_q); end
    in_valid  = 4'b0001;
    in_last   = 4'b0001;
    in_data   = {8'hD3, 8'hD2, 8'hD1, 8'hB0};
    out_ready = 1'b1;
    exp_q.push_back({1'b1, 8'hB0});
    tick();
    checks++; if (gnt !== 4'b0001) begin errors++; $display("FAIL wrap_gnt got %b want 0001", gnt); end
    checks++; if (gnt_idx !== 2'd0) begin errors++; $display("FAIL wrap_gnt_idx got %0d want 0", gnt_idx); end
    checks++;
    if (!(out_valid && out_ready) || exp_q.size() == 0) begin
      errors++; $display("FAIL wrap_beat got valid %b want valid 1", out_valid);
    end else begin
      e = exp_q.pop_front();
      if ({out_last, out_data} !== e) begin errors++; $display("FAIL wrap_beat got %h want %h", {out_last, out_data}, e); end
    end
    tick();
    in_valid = '0;
    #1;
    checks++; if (gnt !== 4'b0000) begin errors++; $display("FAIL wrap_idle got %b want 0000", gnt); end
    checks++; if (dut.base_q !== 4'b0010) begin errors++; $display("FAIL wrap_base got %b want 0010", dut.base_q); end
  endtask

  task automatic test_round_robin();
    int    order[5] = '{0, 1, 2, 3, 0};
    logic  bt[N];
    logic  adv[N];
    logic [N-1:0] eg;
    beat_t e;
    do_reset();
    out_ready = 1'b1;
    for (int i = 0; i < N; i++) bt[i] = 1'b0;
    for (int p = 0; p < 5; p++) begin
      exp_q.push_back({1'b0, 4'(order[p]), 4'd0});
      exp_q.push_back({1'b1, 4'(order[p]), 4'd1});
    end
    for (int c = 0; c < 16; c++) begin
      in_valid = 4'b1111;
      for (int i = 0; i < N; i++) begin
        in_data[i*DATA_W +: DATA_W] = {4'(i), 3'd0, bt[i]};
        in_last[i] = bt[i];
      end
      #1;
      if (c == 0 || (c - 1) % 3 == 2) eg = '0;
      else eg = 4'(1) << order[(c - 1) / 3];
      checks++; if (gnt !== eg) begin errors++; $display("FAIL rr_gnt cycle %0d got %b want %b", c, gnt, eg); end
      if (out_valid && out_ready) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++; $display("FAIL rr_beat cycle %0d got %h want none", c, {out_last, out_data});
        end else begin
          e = exp_q.pop_front();
          if ({out_last, out_data} !== e) begin errors++; $display("FAIL rr_beat cycle %0d got %h want %h", c, {out_last, out_data}, e); end
        end
      end
      for (int i = 0; i < N; i++) adv[i] = in_valid[i] && in_ready[i];
      tick();
      for (int i = 0; i < N; i++) if (adv[i]) bt[i] = ~bt[i];
    end
    checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL rr_left got %0d beats left want 0", exp_q.size()); end
    in_valid = '0;
  endtask

  task automatic test_stall();
    logic [3:0] tv  [10] = '{4'b1010, 4'b1010, 4'b1010, 4'b1000, 4'b1010, 4'b1010, 4'b1010, 4'b1000, 4'b1000, 4'b0000};
    logic [7:0] td1 [10] = '{8'h10, 8'h10, 8'h11, 8'h11, 8'h11, 8'h12, 8'h12, 8'h12, 8'h12, 8'h12};
    logic       tl1 [10] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
    logic       tor [10] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
    logic [3:0] teg [10] = '{4'b0000, 4'b0010, 4'b0010, 4'b0010, 4'b0010, 4'b0010, 4'b0010, 4'b0000, 4'b1000, 4'b0000};
    logic [3:0] ter [10] = '{4'b0000, 4'b0010, 4'b0000, 4'b0010, 4'b0010, 4'b0000, 4'b0010, 4'b0000, 4'b1000, 4'b0000};
    logic       tov [10] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0};
    beat_t e;
    do_reset();
    exp_q.push_back({1'b0, 8'h10});
    exp_q.push_back({1'b0, 8'h11});
    exp_q.push_back({1'b1, 8'h12});
    exp_q.push_back({1'b1, 8'h30});
    for (int c = 0; c < 10; c++) begin
      in_valid  = tv[c];
      in_data   = {8'h30, 8'hD2, td1[c], 8'hD0};
      in_last   = {1'b1, 1'b0, tl1[c], 1'b0};
      out_ready = tor[c];
      #1;
      checks++; if (gnt !== teg[c]) begin errors++; $display("FAIL stall_gnt cycle %0d got %b want %b", c, gnt, teg[c]); end
      checks++; if (in_ready !== ter[c]) begin errors++; $display("FAIL stall_in_ready cycle %0d got %b want %b", c, in_ready, ter[c]); end
      checks++; if (out_valid !== tov[c]) begin errors++; $display("FAIL stall_out_valid cycle %0d got %b want %b", c, out_valid, tov[c]); end
      if (out_valid && out_ready) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++; $display("FAIL stall_beat cycle %0d got %h want none", c, {out_last, out_data});
        end else begin
          e = exp_q.pop_front();
          if ({out_last, out_data} !== e) begin errors++; $display("FAIL stall_beat cycle %0d got %h want %h", c, {out_last, out_data}, e); end
        end
      end
      tick();
    end
    checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL stall_left got %0d beats left want 0", exp_q.size()); end
  endtask

  task automatic test_reset_mid();
    beat_t e;
    do_reset();
    out_ready = 1'b1;
    in_valid  = 4'b0100;
    in_last   = 4'b0100;
    in_data   = {8'hD3, 8'hA0, 8'hD1, 8'hD0};
    exp_q.push_back({1'b1, 8'hA0});
    tick();
    checks++; if (gnt !== 4'b0100) begin errors++; $display("FAIL rmid_gnt1 got %b want 0100", gnt); end
    if (out_valid && out_ready && exp_q.size() != 0) begin
      e = exp_q.pop_front();
      checks++; if ({out_last, out_data} !== e) begin errors++; $display("FAIL rmid_beat1 got %h want %h", {out_last, out_data}, e); end
    end
    tick();
    in_last = 4'b0000;
    in_data = {8'hD3, 8'hA1, 8'hD1, 8'hD0};
    exp_q.push_back({1'b0, 8'hA1});
    #1;
    checks++; if (dut.base_q !== 4'b1000) begin errors++; $display("FAIL rmid_base_pre got %b want 1000", dut.base_q); end
    tick();
    checks++; if (gnt !== 4'b0100) begin errors++; $display("FAIL rmid_gnt2 got %b want 0100", gnt); end
    if (out_valid && out_ready && exp_q.size() != 0) begin
      e = exp_q.pop_front();
      checks++; if ({out_last, out_data} !== e) begin errors++; $display("FAIL rmid_beat2 got %h want %h", {out_last, out_data}, e); end
    end
    tick();
    rst = 1'b1;
    out_ready = 1'b0;
    tick();
    rst = 1'b0;
    in_valid = 4'b1111;
    #1;
    checks++; if (gnt !== 4'b0000) begin errors++; $display("FAIL rmid_gnt got %b want 0000", gnt); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rmid_out_valid got %b want 0", out_valid); end
    checks++; if (in_ready !== 4'b0000) begin errors++; $display("FAIL rmid_in_ready got %b want 0000", in_ready); end
    checks++; if (dut.base_q !== 4'b0001) begin errors++; $display("FAIL rmid_base got %b want 0001", dut.base_q); end
    checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL rmid_left got %0d beats left want 0", exp_q.size()); end
    tick();
    checks++; if (gnt !== 4'b0001) begin errors++; $display("FAIL rmid_regrant got %b want 0001", gnt); end
    checks++; if (gnt_idx !== 2'd0) begin errors++; $display("FAIL rmid_regrant_idx got %0d want 0", gnt_idx); end
  endtask

  task automatic test_random();
    logic [5:0] seq[N];
    int         rem[N];
    int         waits[N];
    int         m_base, m_g, w;
    bit         m_busy, xfer, was_last;
    logic [N-1:0] eg, er;
    beat_t e;
    do_reset();
    for (int q = 0; q < N; q++) rq[q].delete();
    m_base = 0; m_g = 0; m_busy = 1'b0;
    for (int i = 0; i < N; i++) begin
      seq[i] = 6'd0; waits[i] = 0;
      rem[i] = $urandom_range(1, 3);
      for (int b = 0; b < rem[i]; b++) rq[i].push_back({b == rem[i] - 1, 2'(i), 6'(b)});
    end
    for (int c = 0; c < 10000; c++) begin
      out_ready = ($urandom_range(0, 3) != 0);
      for (int i = 0; i < N; i++) begin
        in_valid[i] = ($urandom_range(0, 3) != 0);
        in_last[i]  = (rem[i] == 1);
        in_data[i*DATA_W +: DATA_W] = {2'(i), seq[i]};
      end
      #1;
      eg = m_busy ? (4'(1) << m_g) : 4'b0000;
      er = (m_busy && out_ready) ? eg : 4'b0000;
      checks++; if (gnt !== eg) begin errors++; $display("FAIL rnd_gnt cycle %0d got %b want %b", c, gnt, eg); end
      checks++; if (gnt_idx !== (m_busy ? 2'(m_g) : 2'd0)) begin errors++; $display("FAIL rnd_gnt_idx cycle %0d got %0d want %0d", c, gnt_idx, m_busy ? m_g : 0); end
      checks++; if (in_ready !== er) begin errors++; $display("FAIL rnd_in_ready cycle %0d got %b want %b", c, in_ready, er); end
      checks++; if (out_valid !== (m_busy && in_valid[m_g])) begin errors++; $display("FAIL rnd_out_valid cycle %0d got %b want %b", c, out_valid, m_busy && in_valid[m_g]); end
      xfer = m_busy && in_valid[m_g] && out_ready;
      if (xfer) begin
        checks++;
        if (rq[m_g].size() == 0) begin
          errors++; $display("FAIL rnd_beat cycle %0d got %h want none", c, {out_last, out_data});
        end else begin
          e = rq[m_g].pop_front();
          if ({out_last, out_data} !== e) begin errors++; $display("FAIL rnd_beat cycle %0d req %0d got %h want %h", c, m_g, {out_last, out_data}, e); end
        end
      end
      if (!m_busy) begin
        if (|in_valid) begin
          w = -1;
          for (int k = 0; k < N; k++) if (w < 0 && in_valid[(m_base + k) % N]) w = (m_base + k) % N;
          for (int i = 0; i < N; i++) begin
            if (i == w || !in_valid[i]) waits[i] = 0;
            else waits[i]++;
            checks++; if (waits[i] > N - 1) begin errors++; $display("FAIL rnd_fair cycle %0d req %0d got %0d want <= %0d", c, i, waits[i], N - 1); end
          end
          m_g = w; m_busy = 1'b1;
        end
      end else if (xfer) begin
        was_last = (rem[m_g] == 1);
        seq[m_g] = seq[m_g] + 6'd1;
        rem[m_g] = rem[m_g] - 1;
        if (rem[m_g] == 0) begin
          rem[m_g] = $urandom_range(1, 3);
          for (int b = 0; b < rem[m_g]; b++) rq[m_g].push_back({b == rem[m_g] - 1, 2'(m_g), 6'(seq[m_g] + 6'(b))});
        end
        if (was_last) begin
          m_base = (m_g + 1) % N;
          m_busy = 1'b0;
        end
      end
      tick();
    end
    drive_idle();
  endtask

  initial begin
    rst = 1'b1;
    drive_idle();
    test_reset();
    test_single();
    test_wrap();
    test_round_robin();
    test_stall();
    test_reset_mid();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/lib_rr_arb.md
Name: lib_rr_arb

Overview:
- Round-robin packet arbiter: selects one of N requesters, holds the grant for a whole packet (until `last` accepted), then rotates priority.
- Priority pick is delegated to the library find-first-set block `lib_ffs`, configured for LSB->MSB search with a one-hot base.
- Sits between N streaming sources and a single shared downstream sink (e.g. encoder/channel input mux).

Parameters:
- N, 4, number of requesters (>=2).
- DATA_W, 8, per-requester data width.
- IDX_W, $clog2(N), width of grant index (derived, not overridden).

Ports:
- clk  input  1  single clock, rising edge.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  N  per-requester valid.
- in_last  input  N  per-requester end-of-packet flag, qualified by in_valid.
- in_data  input  N*DATA_W  flat; requester i occupies [i*DATA_W +: DATA_W].
- in_ready  output  N  per-requester ready.
- out_valid  output  1  downstream valid.
- out_last  output  1  downstream end-of-packet.
- out_data  output  DATA_W  downstream data.
- out_ready  input  1  downstream ready.
- gnt  output  N  one-hot current grant, 0 when idle.
- gnt_idx  output  IDX_W  binary index of gnt; 0 when idle.

Behaviour:
- Reset (sync, active-high): state=IDLE, gnt=0, gnt_idx=0, base=one-hot bit0 (requester 0 has top priority), out_valid=0, in_ready=0. Reset mid-packet aborts the packet; no further beats are forwarded.
- FSM states: IDLE, BUSY.
- IDLE:
  - in_ready=0, out_valid=0.
  - If |in_valid, winner = lib_ffs(vect=in_valid, base=base, LSB_MSB=1), i.e. first set bit at or above base, wrapping.
  - Register gnt<=winner and gnt_idx<=encode(winner); go to BUSY.
  - Arbitration latency: 1 cycle from in_valid to gnt.
- BUSY:
  - out_valid=in_valid[gnt_idx], out_data=in_data[gnt_idx], out_last=in_last[gnt_idx]; all combinational.
  - in_ready=gnt & {N{out_ready}}; non-granted requesters see ready=0.
  - A beat transfers when out_valid & out_ready.
  - Transfer with out_last=1: base<=rotate_left(gnt,1), gnt<=0, gnt_idx<=0, go to IDLE. Bubble: one idle cycle between packets; no back-to-back arbitration.
  - Granted requester drops in_valid mid-packet: grant is held and out_valid=0; no timeout, no preemption.
  - Other requesters asserting/deasserting valid while BUSY: no effect.
- Fairness:
  - base always points one past the last winner.
  - With all N requesting continuously, grant order is 0,1,...,N-1,0,...
  - A requester waits at most N-1 packets.
- Wrap-around:
  - Winner N-1 rotates base to bit0.
  - Sole requester below base is still found via lib_ffs wrap.
- Single-beat packet (last on first beat): BUSY lasts exactly one cycle when out_ready=1.
- Invariants (assertions): gnt is one-hot or zero; gnt==0 iff IDLE; base is always one-hot; no in_ready bit high without the matching gnt bit.

Decomposition:
- Shared package `lib_pkg`:
  - State enum type (IDLE, BUSY).
  - onehot-to-binary encode function.
  - rotate-left-by-1 function on N-bit vector.
- Sub-module: one instance of `lib_ffs` (LSB_MSB=1, WIDTH=N) for winner selection. No other sub-modules; the data mux is inline.

Test Plan:
- Reset, then in_valid=4'b0100 with a 1-beat packet and out_ready=1 -> gnt=4'b0100 and gnt_idx=2 one cycle later; one beat out with out_data=data2 and out_last=1; next cycle IDLE with base=4'b1000.
- All four requesting 2-beat packets continuously with out_ready=1 -> grant order 0,1,2,3,0; each packet takes 2 BUSY cycles plus 1 IDLE bubble.
- base=4'b1000 (after a grant to 2), only requester 0 valid -> wrap-around grants requester 0; base becomes 4'b0010.
- Granted requester 1 mid-packet with out_ready toggling 1,0,1 and in_valid[1] dropping one cycle -> no beat lost or duplicated; gnt stays 4'b0010 until last is accepted; requester 3 valid throughout sees in_ready=0.
- rst asserted while BUSY on requester 2 -> next cycle gnt=0, out_valid=0, base=4'b0001; then with all valid, requester 0 wins.
- Random valid/last/ready for 10k cycles with a scoreboard -> per-requester packet order preserved, invariants hold, and no requester waits more than N-1 packets.
